// File: rtl/oursring2mem_slv.sv
// oursring2mem_slv: ring request/response slave bridging to an in-order memory port.
// Define OURSRING2MEM_ADDR_CHK_EN to answer out-of-window addresses with DECERR.
package oursring_pkg;
  localparam int ID_W = 8;

  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [39:0]     awaddr;
  } oursring_req_if_aw_t;

  typedef struct packed {
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
  } oursring_req_if_w_t;

  typedef struct packed {
    logic [ID_W-1:0] arid;
    logic [39:0]     araddr;
  } oursring_req_if_ar_t;

  typedef struct packed {
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
  } oursring_resp_if_b_t;

  typedef struct packed {
    logic [ID_W-1:0] rid;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
  } oursring_resp_if_r_t;
endpackage

module oursring2mem_slv
  import oursring_pkg::*;
#(
  parameter int          OSTD     = 4,
  parameter logic [39:0] MEM_BASE = 40'h0,
  parameter logic [39:0] MEM_SIZE = 40'h10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  oursring_req_if_aw_t aw,
  input  logic                wvalid,
  output logic                wready,
  input  oursring_req_if_w_t  w,
  input  logic                arvalid,
  output logic                arready,
  input  oursring_req_if_ar_t ar,
  output logic                bvalid,
  input  logic                bready,
  output oursring_resp_if_b_t b,
  output logic                rvalid,
  input  logic                rready,
  output oursring_resp_if_r_t r,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [39:0]         mem_req_addr,
  output logic [63:0]         mem_req_wdata,
  output logic [7:0]          mem_req_mask,
  input  logic                mem_rsp_valid,
  input  logic [63:0]         mem_rsp_rdata,
  input  logic                mem_rsp_err
);
  localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam int CW = $clog2(OSTD + 1);

  typedef struct packed {
    logic            wr;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [63:0] data;
    logic [1:0]  resp;
  } rsp_t;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  logic            rq_vld_q, rq_we_q, rq_oor_q;
  logic [ID_W-1:0] rq_id_q;
  logic [39:0]     rq_addr_q;
  logic [63:0]     rq_wdata_q;
  logic [7:0]      rq_mask_q;

  tag_t            tag_mem_q [OSTD];
  logic [PW-1:0]   tag_wp_q, tag_rp_q;
  logic [CW-1:0]   tag_cnt_q, tag_cnt_d;

  rsp_t            rsp_mem_q [OSTD];
  logic [PW-1:0]   rsp_wp_q, rsp_rp_q;
  logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rr_q;

  logic pop, credit_ok, slot_free, elig;
  logic wr_req, rd_req, gnt_wr, gnt_rd, acc;
  logic issue, oor_push, rq_pop;
  logic tag_ne, tag_pop, rsp_ne, rsp_push;
  logic [39:0] acc_addr;
  logic in_win, acc_oor;
  tag_t tag_hd;
  rsp_t rsp_hd, rsp_in;

  // Response side
  assign rsp_ne = (rsp_cnt_q != '0);
  assign rsp_hd = rsp_mem_q[rsp_rp_q];
  assign bvalid = rsp_ne & rsp_hd.tag.wr & ~rst;
  assign rvalid = rsp_ne & ~rsp_hd.tag.wr & ~rst;
  assign b      = '{bid: rsp_hd.tag.id, bresp: rsp_hd.resp};
  assign r      = '{rid: rsp_hd.tag.id, rdata: rsp_hd.data,
                    rresp: rsp_hd.resp, rlast: 1'b1};
  assign pop    = (bvalid & bready) | (rvalid & rready);

  // Acceptance and round-robin arbitration
  assign credit_ok = (cnt_q < CW'(OSTD)) | ((cnt_q == CW'(OSTD)) & pop);
  assign issue     = mem_req_valid & mem_req_ready;
  assign tag_ne    = (tag_cnt_q != '0);
  assign oor_push  = rq_vld_q & rq_oor_q & ~tag_ne;
  assign rq_pop    = issue | oor_push;
  assign slot_free = ~rq_vld_q | rq_pop;
  assign elig      = ~rst & credit_ok & slot_free;
  assign wr_req    = elig & awvalid & wvalid;
  assign rd_req    = elig & arvalid;
  assign gnt_wr    = wr_req & (~rd_req | rr_q);
  assign gnt_rd    = rd_req & ~gnt_wr;
  assign acc       = gnt_wr | gnt_rd;
  assign awready   = gnt_wr;
  assign wready    = gnt_wr;
  assign arready   = gnt_rd;

  assign acc_addr = gnt_wr ? aw.awaddr : ar.araddr;
  assign in_win   = ({1'b0, acc_addr} >= {1'b0, MEM_BASE}) &&
                    ({1'b0, acc_addr} < ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));

`ifdef OURSRING2MEM_ADDR_CHK_EN
  assign acc_oor = ~in_win;
`else
  logic unused_win;
  assign unused_win = in_win;
  assign acc_oor    = 1'b0;
`endif

  logic unused_wlast;
  assign unused_wlast = w.wlast;

  assign mem_req_valid = rq_vld_q & ~rq_oor_q & ~rst;
  assign mem_req_we    = rq_we_q;
  assign mem_req_addr  = rq_addr_q;
  assign mem_req_wdata = rq_wdata_q;
  assign mem_req_mask  = rq_mask_q;

  // Memory response pairing; a DECERR entry only enters once older tags drained
  assign tag_hd   = tag_mem_q[tag_rp_q];
  assign tag_pop  = mem_rsp_valid & tag_ne;
  assign rsp_push = oor_push | tag_pop;

  always_comb begin
    rsp_in = '0;
    if (oor_push) begin
      rsp_in.tag  = '{wr: rq_we_q, id: rq_id_q};
      rsp_in.resp = 2'b11;
    end else begin
      rsp_in.tag  = tag_hd;
      rsp_in.data = mem_rsp_rdata;
      rsp_in.resp = mem_rsp_err ? 2'b10 : 2'b00;
    end
  end

  assign tag_cnt_d = tag_cnt_q + CW'(issue) - CW'(tag_pop);
  assign rsp_cnt_d = rsp_cnt_q + CW'(rsp_push) - CW'(pop);
  assign cnt_d     = cnt_q + CW'(acc) - CW'(pop);

  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[tag_wp_q] <= '{wr: rq_we_q, id: rq_id_q};
    if (rsp_push) rsp_mem_q[rsp_wp_q] <= rsp_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_vld_q   <= 1'b0;
      rq_we_q    <= 1'b0;
      rq_oor_q   <= 1'b0;
      rq_id_q    <= '0;
      rq_addr_q  <= '0;
      rq_wdata_q <= '0;
      rq_mask_q  <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      tag_cnt_q  <= '0;
      rsp_wp_q   <= '0;
      rsp_rp_q   <= '0;
      rsp_cnt_q  <= '0;
      cnt_q      <= '0;
      rr_q       <= 1'b1;
    end else begin
      if (acc) begin
        rq_vld_q   <= 1'b1;
        rq_we_q    <= gnt_wr;
        rq_oor_q   <= acc_oor;
        rq_id_q    <= gnt_wr ? aw.awid : ar.arid;
        rq_addr_q  <= acc_addr;
        rq_wdata_q <= gnt_wr ? w.wdata : '0;
        rq_mask_q  <= gnt_wr ? w.wstrb : '0;
      end else if (rq_pop) begin
        rq_vld_q <= 1'b0;
      end
      if (wr_req & rd_req) rr_q <= gnt_rd;
      if (issue) tag_wp_q <= inc(tag_wp_q);
      if (tag_pop) tag_rp_q <= inc(tag_rp_q);
      if (rsp_push) rsp_wp_q <= inc(rsp_wp_q);
      if (pop) rsp_rp_q <= inc(rsp_rp_q);
      tag_cnt_q <= tag_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_oursring2mem_slv.sv
// Bench for oursring2mem_slv: directed stimulus, scoreboard-checked B/R and memory port.
// Handles both the default build and OURSRING2MEM_ADDR_CHK_EN.
module tb_oursring2mem_slv;
  import oursring_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic awvalid, awready, wvalid, wready, arvalid, arready;
  logic bvalid, bready, rvalid, rready;
  oursring_req_if_aw_t aw;
  oursring_req_if_w_t  w;
  oursring_req_if_ar_t ar;
  oursring_resp_if_b_t b;
  oursring_resp_if_r_t r;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [39:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_mask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_rdata;

  oursring2mem_slv dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .aw(aw),
    .wvalid(wvalid), .wready(wready), .w(w),
    .arvalid(arvalid), .arready(arready), .ar(ar),
    .bvalid(bvalid), .bready(bready), .b(b),
    .rvalid(rvalid), .rready(rready), .r(r),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic        we;
    logic [39:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] rdata;
    logic        err;
  } mexp_t;

  exp_t  sbq[$];
  mexp_t memq[$];
  mexp_t pend[$];
  int checks = 0;
  int failures = 0;
  bit mem_hold = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic expect_wr(input logic [7:0] id, input logic [39:0] a,
                           input logic [63:0] d, input logic [7:0] s,
                           input logic err);
    memq.push_back('{1'b1, a, d, s, 64'h0, err});
    sbq.push_back('{1'b1, id, 64'h0, err ? 2'b10 : 2'b00});
  endtask

  task automatic expect_rd(input logic [7:0] id, input logic [39:0] a,
                           input logic [63:0] d, input logic err);
    memq.push_back('{1'b0, a, 64'h0, 8'h0, d, err});
    sbq.push_back('{1'b0, id, d, err ? 2'b10 : 2'b00});
  endtask

  task automatic drive_wr(input logic [7:0] id, input logic [39:0] a,
                          input logic [63:0] d, input logic [7:0] s);
    bit ok = 1'b0;
    aw = '{awid: id, awaddr: a};
    w  = '{wdata: d, wstrb: s, wlast: 1'b1};
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = awready && wready;
      @(posedge clk); #1;
    end
    if (!ok) chk("wr_accept_timeout", 0, 1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic drive_rd(input logic [7:0] id, input logic [39:0] a);
    bit ok = 1'b0;
    ar = '{arid: id, araddr: a};
    arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
      @(posedge clk); #1;
    end
    if (!ok) chk("rd_accept_timeout", 0, 1);
    arvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bvalid && rvalid) chk("b_and_r_together", 1, 0);
      if ((bvalid && bready) || (rvalid && rready)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", {bvalid, rvalid}, 0);
        end else begin
          e = sbq.pop_front();
          if (bvalid)
            chk("b_response", {1'b1, b.bid, 64'h0, b.bresp, 1'b1},
                {e.wr, e.id, e.data, e.resp, 1'b1});
          else
            chk("r_response", {1'b0, r.rid, r.rdata, r.rresp, r.rlast},
                {e.wr, e.id, e.data, e.resp, 1'b1});
        end
      end
    end
  end

  // Memory model: checks each issued request, answers one cycle later
  initial begin
    mexp_t m;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        if (memq.size() == 0) begin
          chk("unexpected_mem_req", mem_req_addr, 0);
        end else begin
          m = memq.pop_front();
          chk("mem_req",
              {mem_req_we, mem_req_addr,
               mem_req_we ? mem_req_wdata : 64'h0,
               mem_req_we ? mem_req_mask : 8'h0},
              {m.we, m.addr, m.wdata, m.mask});
          pend.push_back(m);
        end
      end
      @(posedge clk); #1;
      if (!mem_hold && pend.size() != 0) begin
        m = pend.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = m.rdata;
        mem_rsp_err   = m.err;
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    string seq;
    int k, wi, ri;
    rst = 1'b1;
    aw = '0; w = '0; ar = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1; mem_req_ready = 1'b1;

    // Reset state with all request valids high
    @(negedge clk);
    chk("reset_outputs",
        {awready, wready, arready, bvalid, rvalid, mem_req_valid}, 6'b0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write, accept-to-issue latency
    expect_wr(8'd3, 40'h100, 64'hA5, 8'hFF, 1'b0);
    aw = '{awid: 8'd3, awaddr: 40'h100};
    w  = '{wdata: 64'hA5, wstrb: 8'hFF, wlast: 1'b0};
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("wr_accept_N", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("mem_req_we_N1", {mem_req_valid, mem_req_we}, 2'b11);
    @(posedge clk); #1;
    drain();

    // Read with memory error
    expect_rd(8'd5, 40'h200, 64'hDEADBEEF, 1'b1);
    drive_rd(8'd5, 40'h200);
    drain();

    // Address without data must wait
    expect_wr(8'd6, 40'h180, 64'h1234, 8'h0F, 1'b0);
    aw = '{awid: 8'd6, awaddr: 40'h180};
    w  = '{wdata: 64'h1234, wstrb: 8'h0F, wlast: 1'b1};
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("aw_only_stall", {awready, wready, mem_req_valid}, 3'b000);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_joint_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    drain();

    // Memory backpressure holds the request stable
    mem_req_ready = 1'b0;
    expect_wr(8'd7, 40'h600, 64'hCAFE_F00D, 8'h3C, 1'b0);
    drive_wr(8'd7, 40'h600, 64'hCAFE_F00D, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mem_req_hold",
          {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_mask},
          {1'b1, 1'b1, 40'h600, 64'hCAFE_F00D, 8'h3C});
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    drain();

    // Credit limit: six reads with R held off
    rready = 1'b0;
    for (int i = 0; i < 6; i++)
      expect_rd(8'(10 + i), 40'h300 + 40'(8 * i), 64'h1000 + 64'(i), 1'b0);
    k = 0;
    arvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ar = '{arid: 8'(10 + k), araddr: 40'h300 + 40'(8 * k)};
      @(negedge clk);
      if (arready) k++;
      @(posedge clk); #1;
    end
    chk("ostd_accepts", k, 4);
    ar = '{arid: 8'(10 + k), araddr: 40'h300 + 40'(8 * k)};
    @(negedge clk);
    chk("arready_blocked", arready, 1'b0);
    @(posedge clk); #1;
    rready = 1'b1;
    @(negedge clk);
    chk("arready_on_pop", arready, 1'b1);
    if (arready) k++;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      ar = '{arid: 8'(10 + k), araddr: 40'h300 + 40'(8 * k)};
      @(negedge clk);
      if (arready) k++;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    chk("ostd_all_accepted", k, 6);
    drain();

    // Contested grants alternate, write first
    expect_wr(8'd1, 40'h400, 64'h11, 8'hFF, 1'b0);
    expect_rd(8'd2, 40'h500, 64'h22, 1'b0);
    expect_wr(8'd3, 40'h408, 64'h33, 8'h0F, 1'b0);
    expect_rd(8'd4, 40'h508, 64'h44, 1'b1);
    seq = "";
    wi = 0; ri = 0;
    for (int c = 0; c < 40 && (wi < 2 || ri < 2); c++) begin
      awvalid = (wi < 2); wvalid = (wi < 2); arvalid = (ri < 2);
      aw = '{awid: wi ? 8'd3 : 8'd1, awaddr: wi ? 40'h408 : 40'h400};
      w  = '{wdata: wi ? 64'h33 : 64'h11, wstrb: wi ? 8'h0F : 8'hFF, wlast: 1'b1};
      ar = '{arid: ri ? 8'd4 : 8'd2, araddr: ri ? 40'h508 : 40'h500};
      @(negedge clk);
      if (awready && arready) chk("double_grant", 1, 0);
      if (awready) begin seq = {seq, "W"}; wi++; end
      else if (arready) begin seq = {seq, "R"}; ri++; end
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (seq != "WRWR") begin
      failures++;
      $display("FAIL grant_order: actual=%s required=WRWR", seq);
    end
    drain();

    // Address at the window end
`ifdef OURSRING2MEM_ADDR_CHK_EN
    expect_rd(8'd8, 40'hFFF8, 64'h55, 1'b0);
    sbq.push_back('{1'b0, 8'd9, 64'h0, 2'b11});
    drive_rd(8'd8, 40'hFFF8);
    drive_rd(8'd9, 40'h10000);
    drain();
`else
    expect_rd(8'd9, 40'h10000, 64'h77, 1'b0);
    drive_rd(8'd9, 40'h10000);
    drain();
`endif

    // Reset with two reads outstanding in memory
    mem_hold = 1'b1;
    memq.push_back('{1'b0, 40'h700, 64'h0, 8'h0, 64'hBAD0, 1'b0});
    memq.push_back('{1'b0, 40'h708, 64'h0, 8'h0, 64'hBAD1, 1'b0});
    drive_rd(8'd20, 40'h700);
    drive_rd(8'd21, 40'h708);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqs_issued", memq.size(), 0);
    rst = 1'b1;
    arvalid = 1'b1;
    ar = '{arid: 8'd22, araddr: 40'h710};
    @(negedge clk);
    chk("mid_reset_outputs",
        {awready, wready, arready, bvalid, rvalid, mem_req_valid}, 6'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    arvalid = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("post_reset_valids", {bvalid, rvalid, mem_req_valid}, 3'b000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_rsp_dropped", {bvalid, rvalid}, 2'b00);
    end
    @(posedge clk); #1;
    chk("late_rsp_released", pend.size(), 0);

    // Normal traffic after reset
    expect_wr(8'd30, 40'h800, 64'h5A5A, 8'hF0, 1'b0);
    drive_wr(8'd30, 40'h800, 64'h5A5A, 8'hF0);
    expect_rd(8'd31, 40'h808, 64'h6B6B, 1'b0);
    drive_rd(8'd31, 40'h808);
    drain();

    chk("memq_empty", memq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oursring2mem_slv.md
OURSRING2MEM_SLV -- requirements
Module: oursring2mem_slv

Interface
REQ-001 SHALL have parameter OSTD, default 4, meaning max accepted-but-unresponded requests (2..16).
REQ-002 SHALL have parameter MEM_BASE, default 40'h0, meaning base of the served address window.
REQ-003 SHALL have parameter MEM_SIZE, default 40'h10000, meaning byte size of the served address window.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports awvalid/awready  in/out  1  plus aw  in  oursring_req_if_aw_t  ring write address (awid, awaddr).
REQ-007 SHALL have ports wvalid/wready  in/out  1  plus w  in  oursring_req_if_w_t  ring write data (wdata 64, wstrb 8, wlast).
REQ-008 SHALL have ports arvalid/arready  in/out  1  plus ar  in  oursring_req_if_ar_t  ring read address (arid, araddr).
REQ-009 SHALL have ports bvalid/bready  out/in  1  plus b  out  oursring_resp_if_b_t  write response (bid, bresp).
REQ-010 SHALL have ports rvalid/rready  out/in  1  plus r  out  oursring_resp_if_r_t  read response (rid, rdata, rresp, rlast).
REQ-011 SHALL have ports mem_req_valid  out  1,  mem_req_ready  in  1,  mem_req_we  out  1,  mem_req_addr  out  40,  mem_req_wdata  out  64,  mem_req_mask  out  8  memory request.
REQ-012 SHALL have ports mem_rsp_valid  in  1,  mem_rsp_rdata  in  64,  mem_rsp_err  in  1  in-order memory response; no backpressure.

Function
REQ-013 SHALL accept a write only when awvalid & wvalid & credit available, asserting awready and wready in the same cycle; aw and w never consumed separately.
REQ-014 SHALL accept a read only when arvalid & credit available, asserting arready.
REQ-015 SHALL, when a write and a read are both eligible in one cycle, accept exactly one, round-robin; pointer starts write-first and flips after each contested grant.
REQ-016 SHALL treat every write as single-beat; wlast is ignored.
REQ-017 SHALL hold the accepted request in a one-entry output register; mem_req_valid rises the cycle after acceptance; a new accept may occur when the register is empty or popped that cycle.
REQ-018 SHALL keep mem_req_* stable while mem_req_valid & ~mem_req_ready.
REQ-019 SHALL push a tag {is_wr, id} to an OSTD-deep tag FIFO when the request is issued (mem_req_valid & mem_req_ready).
REQ-020 SHALL, on mem_rsp_valid, pop the tag FIFO and push {tag, rdata, resp} to an OSTD-deep response FIFO; mem_rsp_valid with empty tag FIFO SHALL be dropped.
REQ-021 SHALL set resp = 2'b10 (SLVERR) if mem_rsp_err, else 2'b00 (OKAY).
REQ-022 SHALL present the response FIFO head on B if is_wr else on R, never both; responses leave in acceptance order; head pops on the selected channel's valid&ready.
REQ-023 SHALL drive rlast = 1 and rdata from memory on R; bid/rid equal the accepted awid/arid.
REQ-024 SHALL keep a credit counter = request register + tag FIFO + response FIFO occupancy, incremented on accept, decremented on B/R handshake; accept allowed only when counter < OSTD, or counter == OSTD with a B/R pop in the same cycle.
REQ-025 SHALL give minimum latency accept N -> mem_req_valid N+1; mem_rsp_valid M -> bvalid/rvalid M+1.

Reset
REQ-026 SHALL, while rst is high, drive awready, wready, arready, bvalid, rvalid, mem_req_valid to 0; empty both FIFOs; zero the credit counter; set arbitration pointer write-first.
REQ-027 SHALL drop in-flight memory responses arriving after a mid-operation reset (tag FIFO empty).

Configuration
REQ-028 SHALL, with OURSRING2MEM_ADDR_CHK_EN defined, bypass memory for accepted addresses outside [MEM_BASE, MEM_BASE+MEM_SIZE) and push {tag, 64'b0, 2'b11 DECERR} directly to the response FIFO, in order behind older responses.
REQ-029 SHALL, without OURSRING2MEM_ADDR_CHK_EN, forward all addresses to memory unchanged.

Verification
REQ-030 Single write awid=3, addr 0x100, wdata 0xA5, wstrb 0xFF, 1-cycle memory -> mem_req_we=1 at N+1; b.bid=3, bresp=0.
REQ-031 Read arid=5 at 0x200, mem_rdata 0xDEADBEEF with mem_rsp_err=1 -> r.rid=5, rdata=0xDEADBEEF, rresp=2'b10, rlast=1.
REQ-032 awvalid=1, wvalid=0 for 5 cycles -> awready stays 0 and no mem request; then wvalid=1 -> both ready in the same cycle.
REQ-033 OSTD=4, bready=rready=0, 6 reads issued -> exactly 4 accepted, arready=0 until one R handshake.
REQ-034 Write and read valid together every cycle -> grants alternate W,R,W,R; B/R order matches.
REQ-035 With macro, read at MEM_BASE+MEM_SIZE -> no mem request; rresp=2'b11, rdata=0; rst asserted with 2 requests outstanding -> all valids 0 the next cycle, late mem_rsp ignored.
